// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_DBG = 1'b1
  } port_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// Grant decision between the CPU and debug ports (purely combinational).
// Build option DMEM_ARB_RR_EN: round-robin on contention in IDLE, else debug wins.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic       cpu_req_i,
  input  logic       dbg_req_i,
  input  arb_state_t state_i,
  input  port_t      last_gnt_i,
  output logic       cpu_gnt_o,
  output logic       dbg_gnt_o
);

  // One grant at most; LOCKED serves only the debug port
  always_comb begin
    cpu_gnt_o = 1'b0;
    dbg_gnt_o = 1'b0;
    if (state_i == LOCKED) begin
      dbg_gnt_o = dbg_req_i;
    end else if (cpu_req_i && dbg_req_i) begin
`ifdef DMEM_ARB_RR_EN
      if (last_gnt_i == PORT_DBG) begin
        cpu_gnt_o = 1'b1;
      end else begin
        dbg_gnt_o = 1'b1;
      end
`else
      dbg_gnt_o = 1'b1;
`endif
    end else begin
      cpu_gnt_o = cpu_req_i;
      dbg_gnt_o = dbg_req_i;
    end
  end

`ifndef DMEM_ARB_RR_EN
  // Fixed priority ignores the grant history
  logic unused_last_gnt;
  assign unused_last_gnt = last_gnt_i;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port synchronous-read data memory between the CPU and a
// debug/loader port, with a debug lock that shuts the CPU out.
// Build option DMEM_ARB_RR_EN: round-robin fairness instead of debug priority.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_gnt_o,
  output logic              cpu_rvalid_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  output logic              dbg_gnt_o,
  output logic              dbg_rvalid_o,
  output logic [DATA_W-1:0] dbg_rdata_o,
  input  logic              dbg_lock_i,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              locked_o
);

  arb_state_t state_q, state_d;
  arb_state_t arb_state;
  logic       pend_q, pend_d;
  port_t      tag_q, tag_d;
  port_t      last_gnt;
  logic       cpu_gnt, dbg_gnt;
  logic       rd_gnt;

  // The cycle dbg_lock drops is already arbitrated as IDLE
  always_comb begin
    arb_state = IDLE;
    if (state_q == LOCKED && dbg_lock_i) begin
      arb_state = LOCKED;
    end
  end

  dmem_arb_pick u_pick (
    .cpu_req_i  (cpu_req_i),
    .dbg_req_i  (dbg_req_i),
    .state_i    (arb_state),
    .last_gnt_i (last_gnt),
    .cpu_gnt_o  (cpu_gnt),
    .dbg_gnt_o  (dbg_gnt)
  );

  assign rd_gnt = (dbg_gnt && !dbg_we_i) || (cpu_gnt && !cpu_we_i);

  // Lock FSM next state and read-owner tag capture
  always_comb begin
    state_d = state_q;
    pend_d  = 1'b0;
    tag_d   = tag_q;
    if (state_q == IDLE) begin
      if (dbg_gnt && dbg_lock_i) begin
        state_d = LOCKED;
      end
    end else begin
      if (!dbg_lock_i) begin
        state_d = IDLE;
      end
    end
    if (rd_gnt) begin
      pend_d = 1'b1;
      tag_d  = dbg_gnt ? PORT_DBG : PORT_CPU;
    end
  end

  // FSM and one-deep read tag pipeline; reset drops any read in flight
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
      tag_q   <= PORT_CPU;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      tag_q   <= tag_d;
    end
  end

`ifdef DMEM_ARB_RR_EN
  port_t last_q, last_d;

  // Remember the most recently granted port, in either state
  always_comb begin
    last_d = last_q;
    if (dbg_gnt) begin
      last_d = PORT_DBG;
    end else if (cpu_gnt) begin
      last_d = PORT_CPU;
    end
  end

  // Last-grant register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= PORT_CPU;
    end else begin
      last_q <= last_d;
    end
  end

  assign last_gnt = last_q;
`else
  assign last_gnt = PORT_CPU;
`endif

  // Memory port carries the granted requester's fields, zero otherwise
  always_comb begin
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (dbg_gnt) begin
      mem_we_o    = dbg_we_i;
      mem_addr_o  = dbg_addr_i;
      mem_wdata_o = dbg_wdata_i;
    end else if (cpu_gnt) begin
      mem_we_o    = cpu_we_i;
      mem_addr_o  = cpu_addr_i;
      mem_wdata_o = cpu_wdata_i;
    end
  end

  assign mem_en_o     = cpu_gnt | dbg_gnt;
  assign cpu_gnt_o    = cpu_gnt;
  assign dbg_gnt_o    = dbg_gnt;
  assign cpu_rvalid_o = pend_q && (tag_q == PORT_CPU);
  assign dbg_rvalid_o = pend_q && (tag_q == PORT_DBG);
  assign cpu_rdata_o  = cpu_rvalid_o ? mem_rdata_i : '0;
  assign dbg_rdata_o  = dbg_rvalid_o ? mem_rdata_i : '0;
  assign locked_o     = (state_q == LOCKED);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus a randomized run against a
// request-level model of the arbiter and memory.
module tb_dmem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
`ifdef DMEM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          cpu_req_i, cpu_we_i, dbg_req_i, dbg_we_i, dbg_lock_i;
  logic [AW-1:0] cpu_addr_i, dbg_addr_i;
  logic [DW-1:0] cpu_wdata_i, dbg_wdata_i;
  logic          cpu_gnt_o, cpu_rvalid_o, dbg_gnt_o, dbg_rvalid_o;
  logic [DW-1:0] cpu_rdata_o, dbg_rdata_o;
  logic          mem_en_o, mem_we_o, locked_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i;

  logic [DW-1:0] mem     [0:255];
  logic [DW-1:0] ref_mem [0:255];

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .cpu_req_i    (cpu_req_i),
    .cpu_we_i     (cpu_we_i),
    .cpu_addr_i   (cpu_addr_i),
    .cpu_wdata_i  (cpu_wdata_i),
    .cpu_gnt_o    (cpu_gnt_o),
    .cpu_rvalid_o (cpu_rvalid_o),
    .cpu_rdata_o  (cpu_rdata_o),
    .dbg_req_i    (dbg_req_i),
    .dbg_we_i     (dbg_we_i),
    .dbg_addr_i   (dbg_addr_i),
    .dbg_wdata_i  (dbg_wdata_i),
    .dbg_gnt_o    (dbg_gnt_o),
    .dbg_rvalid_o (dbg_rvalid_o),
    .dbg_rdata_o  (dbg_rdata_o),
    .dbg_lock_i   (dbg_lock_i),
    .mem_en_o     (mem_en_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i),
    .locked_o     (locked_o)
  );

  // Synchronous-read memory macro
  always @(posedge clk_i) begin
    if (mem_en_o) begin
      if (mem_we_o) mem[mem_addr_o[9:2]] = mem_wdata_o;
      else          mem_rdata_i <= mem[mem_addr_o[9:2]];
    end
  end

  task automatic clear_inputs();
    cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_wdata_i = '0;
    dbg_req_i = 1'b0; dbg_we_i = 1'b0; dbg_addr_i = '0; dbg_wdata_i = '0;
    dbg_lock_i = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    checks++;
    if ({cpu_gnt_o, dbg_gnt_o, cpu_rvalid_o, dbg_rvalid_o, locked_o, mem_en_o, mem_we_o} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=0", {cpu_gnt_o, dbg_gnt_o, cpu_rvalid_o, dbg_rvalid_o, locked_o, mem_en_o, mem_we_o});
    end
    checks++;
    if ({cpu_rdata_o, dbg_rdata_o, mem_addr_o, mem_wdata_o} !== 128'h0) begin
      errors++; $display("FAIL reset_data got=%h exp=0", {cpu_rdata_o, dbg_rdata_o, mem_addr_o, mem_wdata_o});
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_cpu_read();
    @(negedge clk_i);
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h10;
    #1;
    checks++;
    if ({cpu_gnt_o, dbg_gnt_o, mem_en_o, mem_we_o} !== 4'b1010) begin
      errors++; $display("FAIL cpu_read_gnt got=%b exp=1010", {cpu_gnt_o, dbg_gnt_o, mem_en_o, mem_we_o});
    end
    checks++;
    if (mem_addr_o !== 32'h10) begin
      errors++; $display("FAIL cpu_read_addr got=%h exp=00000010", mem_addr_o);
    end
    @(negedge clk_i);
    cpu_req_i = 1'b0;
    #1;
    checks++;
    if ({cpu_rvalid_o, cpu_rdata_o} !== {1'b1, 32'hDEADBEEF}) begin
      errors++; $display("FAIL cpu_read_resp got=%b/%h exp=1/deadbeef", cpu_rvalid_o, cpu_rdata_o);
    end
    checks++;
    if ({dbg_rvalid_o, dbg_rdata_o} !== 33'h0) begin
      errors++; $display("FAIL cpu_read_dbg_quiet got=%b/%h exp=0/0", dbg_rvalid_o, dbg_rdata_o);
    end
    @(negedge clk_i);
    #1;
    checks++;
    if ({cpu_rvalid_o, dbg_rvalid_o} !== 2'b00) begin
      errors++; $display("FAIL cpu_read_single got=%b exp=00", {cpu_rvalid_o, dbg_rvalid_o});
    end
  endtask

  task automatic test_simultaneous();
    logic first_dbg;
    logic [DW-1:0] e_first, e_second;
    first_dbg = !RR_EN;
    e_first   = first_dbg ? 32'hCAFE0001 : 32'hDEADBEEF;
    e_second  = first_dbg ? 32'hDEADBEEF : 32'hCAFE0001;
    // debug write leaves the debug port as most recent grant
    @(negedge clk_i);
    dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 32'h40; dbg_wdata_i = 32'hCAFE0001;
    #1;
    checks++;
    if ({cpu_gnt_o, dbg_gnt_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o} !== {4'b0111, 32'h40, 32'hCAFE0001}) begin
      errors++; $display("FAIL sim_dbg_write got=%b %h %h exp=0111 00000040 cafe0001", {cpu_gnt_o, dbg_gnt_o, mem_en_o, mem_we_o}, mem_addr_o, mem_wdata_o);
    end
    @(negedge clk_i);
    dbg_we_i = 1'b0;
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h10;
    #1;
    checks++;
    if ({cpu_gnt_o, dbg_gnt_o} !== {~first_dbg, first_dbg}) begin
      errors++; $display("FAIL sim_first_gnt got=%b exp=%b", {cpu_gnt_o, dbg_gnt_o}, {~first_dbg, first_dbg});
    end
    @(negedge clk_i);
    if (first_dbg) dbg_req_i = 1'b0;
    else           cpu_req_i = 1'b0;
    #1;
    checks++;
    if ({cpu_gnt_o, dbg_gnt_o} !== {first_dbg, ~first_dbg}) begin
      errors++; $display("FAIL sim_second_gnt got=%b exp=%b", {cpu_gnt_o, dbg_gnt_o}, {first_dbg, ~first_dbg});
    end
    checks++;
    if ({cpu_rvalid_o, dbg_rvalid_o, (first_dbg ? dbg_rdata_o : cpu_rdata_o)} !== {~first_dbg, first_dbg, e_first}) begin
      errors++; $display("FAIL sim_first_resp got=%b%b %h exp=%b %h", cpu_rvalid_o, dbg_rvalid_o, (first_dbg ? dbg_rdata_o : cpu_rdata_o), {~first_dbg, first_dbg}, e_first);
    end
    @(negedge clk_i);
    clear_inputs();
    #1;
    checks++;
    if ({cpu_rvalid_o, dbg_rvalid_o, (first_dbg ? cpu_rdata_o : dbg_rdata_o)} !== {first_dbg, ~first_dbg, e_second}) begin
      errors++; $display("FAIL sim_second_resp got=%b%b %h exp=%b %h", cpu_rvalid_o, dbg_rvalid_o, (first_dbg ? cpu_rdata_o : dbg_rdata_o), {first_dbg, ~first_dbg}, e_second);
    end
  endtask

  task automatic test_lock();
    @(negedge clk_i);
    dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 32'h20; dbg_wdata_i = 32'h1234; dbg_lock_i = 1'b1;
    #1;
    checks++;
    if ({dbg_gnt_o, cpu_gnt_o, locked_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o} !== {5'b10011, 32'h20, 32'h1234}) begin
      errors++; $display("FAIL lock_write got=%b %h %h exp=10011 00000020 00001234", {dbg_gnt_o, cpu_gnt_o, locked_o, mem_en_o, mem_we_o}, mem_addr_o, mem_wdata_o);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      dbg_req_i = 1'b0;
      cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h10;
      #1;
      checks++;
      if ({locked_o, cpu_gnt_o, mem_en_o} !== 3'b100) begin
        errors++; $display("FAIL lock_cpu_blocked[%0d] got=%b exp=100", i, {locked_o, cpu_gnt_o, mem_en_o});
      end
    end
    @(negedge clk_i);
    dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 32'h20;
    #1;
    checks++;
    if ({dbg_gnt_o, cpu_gnt_o, locked_o} !== 3'b101) begin
      errors++; $display("FAIL lock_dbg_read got=%b exp=101", {dbg_gnt_o, cpu_gnt_o, locked_o});
    end
    @(negedge clk_i);
    dbg_req_i = 1'b0; dbg_lock_i = 1'b0;
    #1;
    checks++;
    if ({cpu_gnt_o, dbg_gnt_o} !== 2'b10) begin
      errors++; $display("FAIL lock_release_gnt got=%b exp=10", {cpu_gnt_o, dbg_gnt_o});
    end
    checks++;
    if ({dbg_rvalid_o, dbg_rdata_o, cpu_rvalid_o} !== {1'b1, 32'h1234, 1'b0}) begin
      errors++; $display("FAIL lock_dbg_resp got=%b/%h cpu_rv=%b exp=1/00001234 cpu_rv=0", dbg_rvalid_o, dbg_rdata_o, cpu_rvalid_o);
    end
    @(negedge clk_i);
    clear_inputs();
    #1;
    checks++;
    if ({cpu_rvalid_o, cpu_rdata_o, locked_o} !== {1'b1, 32'hDEADBEEF, 1'b0}) begin
      errors++; $display("FAIL lock_cpu_resp got=%b/%h locked=%b exp=1/deadbeef locked=0", cpu_rvalid_o, cpu_rdata_o, locked_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] e_data;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk_i);
      clear_inputs();
      if (i < 8) begin
        if (i % 2 == 0) begin
          cpu_req_i = 1'b1; cpu_addr_i = 32'h100 + 32'(4 * i);
        end else begin
          dbg_req_i = 1'b1; dbg_addr_i = 32'h100 + 32'(4 * i);
        end
      end
      #1;
      if (i < 8) begin
        checks++;
        if ({cpu_gnt_o, dbg_gnt_o} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
          errors++; $display("FAIL b2b_gnt[%0d] got=%b", i, {cpu_gnt_o, dbg_gnt_o});
        end
      end
      if (i > 0) begin
        e_data = 32'hA500_0000 | 32'(63 + i);
        checks++;
        if ({cpu_rvalid_o, dbg_rvalid_o} !== (((i - 1) % 2 == 0) ? 2'b10 : 2'b01) ||
            (cpu_rdata_o | dbg_rdata_o) !== e_data) begin
          errors++; $display("FAIL b2b_resp[%0d] got=%b %h exp_data=%h", i, {cpu_rvalid_o, dbg_rvalid_o}, (cpu_rdata_o | dbg_rdata_o), e_data);
        end
      end
    end
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk_i);
    clear_inputs();
    cpu_req_i = 1'b1; cpu_addr_i = 32'h10;
    #1;
    checks++;
    if (cpu_gnt_o !== 1'b1) begin
      errors++; $display("FAIL rst_mid_gnt got=%b exp=1", cpu_gnt_o);
    end
    @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    clear_inputs();
    #1;
    checks++;
    if ({cpu_gnt_o, dbg_gnt_o, cpu_rvalid_o, dbg_rvalid_o, locked_o, mem_en_o, mem_we_o, cpu_rdata_o, dbg_rdata_o, mem_addr_o, mem_wdata_o} !== 135'h0) begin
      errors++; $display("FAIL rst_mid_outputs got=%b rdata=%h/%h exp=0", {cpu_gnt_o, dbg_gnt_o, cpu_rvalid_o, dbg_rvalid_o, locked_o, mem_en_o, mem_we_o}, cpu_rdata_o, dbg_rdata_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      #1;
      checks++;
      if ({cpu_rvalid_o, dbg_rvalid_o} !== 2'b00) begin
        errors++; $display("FAIL rst_mid_no_rvalid[%0d] got=%b exp=00", i, {cpu_rvalid_o, dbg_rvalid_o});
      end
    end
  endtask

  task automatic test_lock_no_req();
    @(negedge clk_i);
    clear_inputs();
    dbg_lock_i = 1'b1;
    cpu_req_i = 1'b1; cpu_addr_i = 32'h10;
    #1;
    checks++;
    if ({cpu_gnt_o, dbg_gnt_o, locked_o} !== 3'b100) begin
      errors++; $display("FAIL lock_noreq_gnt got=%b exp=100", {cpu_gnt_o, dbg_gnt_o, locked_o});
    end
    @(negedge clk_i);
    cpu_req_i = 1'b0;
    #1;
    checks++;
    if ({locked_o, cpu_rvalid_o, cpu_rdata_o} !== {2'b01, 32'hDEADBEEF}) begin
      errors++; $display("FAIL lock_noreq_state got=locked %b rv %b %h exp=locked 0 rv 1 deadbeef", locked_o, cpu_rvalid_o, cpu_rdata_o);
    end
    @(negedge clk_i);
    clear_inputs();
  endtask

  task automatic test_random();
    bit            m_lock, m_last, rv_v, rv_p, lock;
    logic [DW-1:0] rv_d;
    bit            c_act, d_act, eg_c, eg_d;
    logic          c_we, d_we, e_we;
    logic [AW-1:0] c_addr, d_addr, e_addr;
    logic [DW-1:0] c_wd, d_wd, e_wd, v;
    @(negedge clk_i);
    clear_inputs();
    rst_ni = 1'b0;
    for (int k = 0; k < 256; k++) begin
      v = $urandom;
      mem[k] = v;
      ref_mem[k] = v;
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    m_lock = 0; m_last = 0; rv_v = 0; rv_p = 0; rv_d = '0; lock = 0;
    c_act = 0; d_act = 0;
    c_we = 0; d_we = 0; c_addr = '0; d_addr = '0; c_wd = '0; d_wd = '0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk_i);
      if (!c_act && $urandom_range(0, 3) != 0) begin
        c_act = 1; c_we = ($urandom_range(0, 2) == 0);
        c_addr = 32'($urandom_range(0, 15)) << 2; c_wd = $urandom;
      end
      if (!d_act && $urandom_range(0, 3) != 0) begin
        d_act = 1; d_we = ($urandom_range(0, 2) == 0);
        d_addr = 32'($urandom_range(0, 15)) << 2; d_wd = $urandom;
      end
      if ($urandom_range(0, 7) == 0) lock = ~lock;
      cpu_req_i = c_act; cpu_we_i = c_we; cpu_addr_i = c_addr; cpu_wdata_i = c_wd;
      dbg_req_i = d_act; dbg_we_i = d_we; dbg_addr_i = d_addr; dbg_wdata_i = d_wd;
      dbg_lock_i = lock;
      // expected winner this cycle
      eg_c = 0; eg_d = 0;
      if (m_lock && lock) begin
        eg_d = d_act;
      end else if (c_act && d_act) begin
        if (RR_EN && m_last) eg_c = 1;
        else                 eg_d = 1;
      end else begin
        eg_c = c_act; eg_d = d_act;
      end
      e_we = 0; e_addr = '0; e_wd = '0;
      if (eg_d)      begin e_we = d_we; e_addr = d_addr; e_wd = d_wd; end
      else if (eg_c) begin e_we = c_we; e_addr = c_addr; e_wd = c_wd; end
      #1;
      checks++;
      if ({cpu_gnt_o, dbg_gnt_o, mem_en_o, mem_we_o} !== {eg_c, eg_d, eg_c | eg_d, e_we}) begin
        errors++; $display("FAIL rnd_gnt[%0d] got=%b exp=%b", n, {cpu_gnt_o, dbg_gnt_o, mem_en_o, mem_we_o}, {eg_c, eg_d, eg_c | eg_d, e_we});
      end
      checks++;
      if ({mem_addr_o, mem_wdata_o} !== {e_addr, e_wd}) begin
        errors++; $display("FAIL rnd_mem[%0d] got=%h/%h exp=%h/%h", n, mem_addr_o, mem_wdata_o, e_addr, e_wd);
      end
      checks++;
      if ({cpu_rvalid_o, dbg_rvalid_o, cpu_rdata_o, dbg_rdata_o} !==
          {rv_v & ~rv_p, rv_v & rv_p, (rv_v && !rv_p) ? rv_d : 32'h0, (rv_v && rv_p) ? rv_d : 32'h0}) begin
        errors++; $display("FAIL rnd_resp[%0d] got=%b%b %h/%h exp_v=%b port=%b data=%h", n, cpu_rvalid_o, dbg_rvalid_o, cpu_rdata_o, dbg_rdata_o, rv_v, rv_p, rv_d);
      end
      checks++;
      if (locked_o !== m_lock) begin
        errors++; $display("FAIL rnd_locked[%0d] got=%b exp=%b", n, locked_o, m_lock);
      end
      // commit this cycle's effects
      rv_v = 0;
      if (eg_c || eg_d) begin
        if (e_we) ref_mem[e_addr[9:2]] = e_wd;
        else begin rv_v = 1; rv_p = eg_d; rv_d = ref_mem[e_addr[9:2]]; end
        m_last = eg_d;
      end
      m_lock = lock && (m_lock || eg_d);
      if (eg_c) c_act = 0;
      if (eg_d) d_act = 0;
    end
    @(negedge clk_i);
    clear_inputs();
  endtask

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 32'hA500_0000 | 32'(k);
    mem[4] = 32'hDEADBEEF;
    clear_inputs();
    test_reset();
    test_cpu_read();
    test_simultaneous();
    test_lock();
    test_back_to_back();
    test_reset_mid_read();
    test_lock_no_req();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
